// File: rtl/mpp_tile_gate_pipe.sv
// -----------------------------------------------------------------------------
// mpp_tile_gate_pipe
//
// Partial-product tile gate for the multi-precision mantissa multiplier.
// The sub-multiplier array delivers a LANES x LANES grid of SUB_W-bit
// sub-products. Precision mode k fuses 2^k neighbouring lanes into one wider
// multiply. Only tiles whose row and column fall in the same fused group
// belong to that product, so every other tile is forced to zero here.
//
// The block is a two-stage valid/ready pipeline:
//   S1 : registers the raw tile array and mode on an input handshake.
//   S2 : registers the gated tiles, pass mask, mode and illegal flag.
// A small FSM keeps tiles of different modes out of the pipeline at the same
// time. When a new mode shows up while older work is in flight, input is
// stalled until the pipeline has fully drained.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     upstream tile array valid
//   in_ready     block accepts in_pp/in_op this cycle
//   in_pp        tile (i,j) at bits [(i*LANES+j)*SUB_W +: SUB_W]
//   in_op        precision mode k (group size 2^k)
//   out_valid    gated result valid
//   out_ready    downstream accepts
//   out_pp       gated tiles, same ordering as in_pp
//   out_mask     bit i*LANES+j set iff tile (i,j) passed
//   out_op       mode that produced out_pp
//   out_illegal  result came from an illegal mode (all tiles zero)
// -----------------------------------------------------------------------------
module mpp_tile_gate_pipe #(
    parameter int SUB_W  = 14,
    parameter int LANES  = 4,
    parameter int MODE_W = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*LANES*SUB_W-1:0] in_pp,
    input  logic [MODE_W-1:0]            in_op,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*LANES*SUB_W-1:0] out_pp,
    output logic [LANES*LANES-1:0]       out_mask,
    output logic [MODE_W-1:0]            out_op,
    output logic                         out_illegal
);

    localparam int          NT         = LANES * LANES;
    localparam int          PPW        = NT * SUB_W;
    localparam int unsigned LOG2_LANES = $clog2(LANES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              state_reg;
    state_t              state_next;

    // Stage 1: raw tile array and its mode
    logic                s1_valid_reg;
    logic [PPW-1:0]      s1_pp_reg;
    logic [MODE_W-1:0]   s1_op_reg;

    // Stage 2: gated result (drives the outputs directly)
    logic                s2_valid_reg;
    logic [PPW-1:0]      s2_pp_reg;
    logic [NT-1:0]       s2_mask_reg;
    logic [MODE_W-1:0]   s2_op_reg;
    logic                s2_illegal_reg;

    // Mode of the most recently accepted transfer
    logic [MODE_W-1:0]   cur_op_reg;

    // Flow-control terms
    logic                s2_load;
    logic                s1_free;
    logic                op_match;
    logic                in_fire;
    logic                s1_valid_next;
    logic                s2_valid_next;
    logic                pipe_empty_next;

    // Gating datapath between S1 and S2
    logic [31:0]         s1_op_ext;
    logic                s1_legal;
    logic [NT-1:0]       gate_mask;
    logic [PPW-1:0]      gate_pp;

    // -------------------------------------------------------------------------
    // Flow control
    // -------------------------------------------------------------------------
    // S2 can take new data when it is empty or its content leaves this cycle;
    // S1 moves into S2 under the same condition, which frees S1 as well.
    assign s2_load  = !s2_valid_reg || out_ready;
    assign s1_free  = !s1_valid_reg || s2_load;
    assign op_match = (in_op == cur_op_reg);

    // in_ready depends on registered state and out_ready; the only path from
    // the input side is the mode compare while running.
    always_comb begin
        in_ready = 1'b0;
        case (state_reg)
            ST_IDLE:  in_ready = 1'b1;
            ST_RUN:   in_ready = s1_free && (!in_valid || op_match);
            ST_DRAIN: in_ready = 1'b0;
            default:  in_ready = 1'b0;
        endcase
    end

    assign in_fire         = in_valid && in_ready;
    assign s1_valid_next   = in_fire || (s1_valid_reg && !s2_load);
    assign s2_valid_next   = s2_load ? s1_valid_reg : s2_valid_reg;
    assign pipe_empty_next = !s1_valid_next && !s2_valid_next;

    // -------------------------------------------------------------------------
    // Mode FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // In RUN an emptying pipeline wins over a pending mode change: the new
    // mode is then simply accepted from IDLE on the next cycle instead of
    // spending an extra cycle in DRAIN with nothing left to drain.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_fire) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (pipe_empty_next) begin
                    state_next = ST_IDLE;
                end else if (in_valid && !op_match) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty_next) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_op_reg <= '0;
        end else if (in_fire) begin
            cur_op_reg <= in_op;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 1
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_pp_reg    <= '0;
            s1_op_reg    <= '0;
        end else begin
            s1_valid_reg <= s1_valid_next;
            if (in_fire) begin
                s1_pp_reg <= in_pp;
                s1_op_reg <= in_op;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Tile gating
    // -------------------------------------------------------------------------
    // Mode k is legal while the group size 2^k does not exceed LANES. Tile
    // (i,j) belongs to the fused product when row and column share a group,
    // i.e. (i >> k) == (j >> k).
    assign s1_op_ext = 32'(s1_op_reg);
    assign s1_legal  = (s1_op_ext <= LOG2_LANES);

    for (genvar gi = 0; gi < NT; gi++) begin : g_tile
        localparam int unsigned TILE_I = gi / LANES;
        localparam int unsigned TILE_J = gi % LANES;

        assign gate_mask[gi] = s1_legal &&
                               ((TILE_I >> s1_op_ext) == (TILE_J >> s1_op_ext));
        assign gate_pp[gi*SUB_W +: SUB_W] = gate_mask[gi] ?
                                            s1_pp_reg[gi*SUB_W +: SUB_W] :
                                            {SUB_W{1'b0}};
    end

    // -------------------------------------------------------------------------
    // Stage 2
    // -------------------------------------------------------------------------
    // Payload only changes when a valid S1 entry moves in, so the outputs stay
    // put while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg   <= 1'b0;
            s2_pp_reg      <= '0;
            s2_mask_reg    <= '0;
            s2_op_reg      <= '0;
            s2_illegal_reg <= 1'b0;
        end else begin
            s2_valid_reg <= s2_valid_next;
            if (s2_load && s1_valid_reg) begin
                s2_pp_reg      <= gate_pp;
                s2_mask_reg    <= gate_mask;
                s2_op_reg      <= s1_op_reg;
                s2_illegal_reg <= !s1_legal;
            end
        end
    end

    assign out_valid   = s2_valid_reg;
    assign out_pp      = s2_pp_reg;
    assign out_mask    = s2_mask_reg;
    assign out_op      = s2_op_reg;
    assign out_illegal = s2_illegal_reg;

endmodule

// File: tb/tb_mpp_tile_gate_pipe.sv
// -----------------------------------------------------------------------------
// tb_mpp_tile_gate_pipe
//
// Self-checking bench for mpp_tile_gate_pipe (LANES=4, SUB_W=14, MODE_W=2).
// A behavioural model computes gated results from the group rule with plain
// division, and a queue holds results that were accepted but not yet popped.
// in_ready is predicted from the number of items in flight and the mode of
// the last accepted transfer.
// -----------------------------------------------------------------------------
module tb_mpp_tile_gate_pipe;

    localparam int SUB_W  = 14;
    localparam int LANES  = 4;
    localparam int MODE_W = 2;
    localparam int NT     = LANES * LANES;
    localparam int PPW    = NT * SUB_W;

    typedef struct packed {
        logic [PPW-1:0]    pp;
        logic [NT-1:0]     mask;
        logic [MODE_W-1:0] op;
        logic              ill;
    } res_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [PPW-1:0]      in_pp = '0;
    logic [MODE_W-1:0]   in_op = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [PPW-1:0]      out_pp;
    logic [NT-1:0]       out_mask;
    logic [MODE_W-1:0]   out_op;
    logic                out_illegal;

    int                  vectors = 0;
    int                  errors  = 0;
    res_t                sb[$];
    logic [MODE_W-1:0]   last_op = '0;

    mpp_tile_gate_pipe #(
        .SUB_W (SUB_W),
        .LANES (LANES),
        .MODE_W(MODE_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pp      (in_pp),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pp     (out_pp),
        .out_mask   (out_mask),
        .out_op     (out_op),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // Reference: group size g = 2^op; legal while g <= LANES; tile (i,j)
    // survives when i and j land in the same group of g lanes.
    function automatic res_t model(input logic [PPW-1:0] pp, input logic [MODE_W-1:0] op);
        res_t r;
        int   g;
        r     = '0;
        r.op  = op;
        g     = 1 << op;
        r.ill = (g > LANES);
        for (int i = 0; i < LANES; i++) begin
            for (int j = 0; j < LANES; j++) begin
                if (!r.ill && (i / g) == (j / g)) begin
                    r.mask[i*LANES+j] = 1'b1;
                    r.pp[(i*LANES+j)*SUB_W +: SUB_W] = pp[(i*LANES+j)*SUB_W +: SUB_W];
                end
            end
        end
        return r;
    endfunction

    // Two items fit in flight; a different mode must wait for an empty pipe.
    function automatic logic exp_ready(input int n, input logic iv,
                                       input logic [MODE_W-1:0] op, input logic ordy);
        if (n == 0) return 1'b1;
        if (iv && op != last_op) return 1'b0;
        return (n < 2) || ordy;
    endfunction

    function automatic logic [PPW-1:0] rand_pp();
        logic [PPW-1:0] p;
        for (int k = 0; k < NT; k++) p[k*SUB_W +: SUB_W] = SUB_W'($urandom);
        return p;
    endfunction

    // Drive one cycle of inputs (called at posedge+1), sample at the negedge.
    task automatic step(input logic iv, input logic [PPW-1:0] pp, input logic [MODE_W-1:0] op,
                        input logic ordy, output logic ir, output res_t o, output logic ov);
        in_valid  = iv;
        in_pp     = pp;
        in_op     = op;
        out_ready = ordy;
        @(negedge clk);
        ir = in_ready;
        ov = out_valid;
        o  = {out_pp, out_mask, out_op, out_illegal};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        vectors++;
        if ({out_valid, out_pp, out_mask, out_op, out_illegal} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%0b mask=%h op=%0d ill=%0b, required all zero",
                     out_valid, out_mask, out_op, out_illegal);
        end
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;
        begin
            logic ir, ov; res_t o;
            step(1'b0, '0, '0, 1'b1, ir, o, ov);
            vectors++;
            if (ir !== 1'b1 || ov !== 1'b0) begin
                errors++;
                $display("FAIL reset_release: in_ready=%0b out_valid=%0b, required 1 and 0", ir, ov);
            end
        end
    endtask

    task automatic test_mode_sweep();
        logic [15:0]    tbl [4];
        logic [PPW-1:0] pp;
        logic           ir, ov;
        res_t           o;
        tbl[0] = 16'h8421; tbl[1] = 16'hCC33; tbl[2] = 16'hFFFF; tbl[3] = 16'h0000;
        pp = '1;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, pp, MODE_W'(k), 1'b1, ir, o, ov);
            vectors++;
            if (ir !== 1'b1) begin
                errors++;
                $display("FAIL sweep_accept op=%0d: in_ready=%0b, required 1", k, ir);
            end
            step(1'b0, '0, '0, 1'b1, ir, o, ov);
            vectors++;
            if (ov !== 1'b0) begin
                errors++;
                $display("FAIL sweep_early op=%0d: out_valid=%0b one cycle after accept, required 0", k, ov);
            end
            step(1'b0, '0, '0, 1'b1, ir, o, ov);
            vectors++;
            if (ov !== 1'b1 || o.mask !== tbl[k] || o.ill !== (k == 3)) begin
                errors++;
                $display("FAIL sweep_result op=%0d: valid=%0b mask=%h ill=%0b, required 1 %h %0b",
                         k, ov, o.mask, o.ill, tbl[k], (k == 3));
            end
            vectors++;
            if (o !== model(pp, MODE_W'(k))) begin
                errors++;
                $display("FAIL sweep_data op=%0d: mask=%h op=%0d, required mask=%h op=%0d",
                         k, o.mask, o.op, tbl[k], k);
            end
            step(1'b0, '0, '0, 1'b1, ir, o, ov);
        end
    endtask

    task automatic test_throughput();
        logic [PPW-1:0] pp;
        logic           ir, ov;
        res_t           o, e;
        int             pops = 0;
        for (int c = 0; c < 12; c++) begin
            pp = '0;
            for (int t = 0; t < NT; t++) pp[t*SUB_W +: SUB_W] = SUB_W'(t + 1 + c * 16);
            step(c < 8, pp, 2'd1, 1'b1, ir, o, ov);
            if (c < 8) begin
                vectors++;
                if (ir !== 1'b1) begin
                    errors++;
                    $display("FAIL thru_ready cyc=%0d: in_ready=%0b, required 1", c, ir);
                end
            end
            vectors++;
            if (ov !== (c >= 2 && c < 10)) begin
                errors++;
                $display("FAIL thru_valid cyc=%0d: out_valid=%0b, required %0b", c, ov, (c >= 2 && c < 10));
            end
            if (ov) begin
                e = model({PPW{1'b0}}, 2'd1);
                for (int t = 0; t < NT; t++) e.pp[t*SUB_W +: SUB_W] = SUB_W'(t + 1 + pops * 16);
                e = model(e.pp, 2'd1);
                vectors++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL thru_data item=%0d: tile01=%0d tile02=%0d, required %0d %0d",
                             pops, o.pp[1*SUB_W +: SUB_W], o.pp[2*SUB_W +: SUB_W],
                             e.pp[1*SUB_W +: SUB_W], e.pp[2*SUB_W +: SUB_W]);
                end
                if (pops == 0) begin
                    vectors++;
                    if (o.pp[1*SUB_W +: SUB_W] !== 14'd2 || o.pp[2*SUB_W +: SUB_W] !== 14'd0) begin
                        errors++;
                        $display("FAIL thru_tiles: tile01=%0d tile02=%0d, required 2 0",
                                 o.pp[1*SUB_W +: SUB_W], o.pp[2*SUB_W +: SUB_W]);
                    end
                end
                pops++;
            end
        end
        last_op = 2'd1;
    endtask

    task automatic test_backpressure();
        logic [PPW-1:0]    pp;
        logic [MODE_W-1:0] op;
        logic              ir, ov, ordy, xr, stall_prev;
        res_t              o, o_prev;
        int                sent = 0, got = 0, cyc = 0;
        op = MODE_W'($urandom_range(0, 2));
        pp = rand_pp();
        stall_prev = 1'b0;
        o_prev = '0;
        while ((sent < 10 || sb.size() > 0) && cyc < 200) begin
            ordy = (cyc >= 5);
            xr = exp_ready(sb.size(), sent < 10, op, ordy);
            step(sent < 10, pp, op, ordy, ir, o, ov);
            vectors++;
            if (ir !== xr) begin
                errors++;
                $display("FAIL bp_ready cyc=%0d: in_ready=%0b, required %0b", cyc, ir, xr);
            end
            if (stall_prev) begin
                vectors++;
                if (ov !== 1'b1 || o !== o_prev) begin
                    errors++;
                    $display("FAIL bp_hold cyc=%0d: valid=%0b mask=%h, required 1 %h", cyc, ov, o.mask, o_prev.mask);
                end
            end
            if (ov && ordy) begin
                vectors++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL bp_spurious cyc=%0d: out_valid=1, required 0 (nothing in flight)", cyc);
                end else begin
                    if (o !== sb[0]) begin
                        errors++;
                        $display("FAIL bp_data item=%0d: mask=%h op=%0d, required mask=%h op=%0d",
                                 got, o.mask, o.op, sb[0].mask, sb[0].op);
                    end
                    void'(sb.pop_front());
                    got++;
                end
            end
            if (sent < 10 && ir) begin
                sb.push_back(model(pp, op));
                last_op = op;
                sent++;
                pp = rand_pp();
            end
            stall_prev = ov && !ordy;
            o_prev = o;
            cyc++;
        end
        vectors++;
        if (got != 10) begin
            errors++;
            $display("FAIL bp_count: results=%0d, required 10", got);
        end
    endtask

    // mode_sel 0: 4 items op=0 then 2 items op=2 with random out_ready.
    // mode_sel 1: 12 items of one random op with out_ready toggling.
    task automatic test_stream(input int mode_sel);
        logic [PPW-1:0]    pp;
        logic [MODE_W-1:0] op, sop;
        logic              ir, ov, ordy, xr;
        res_t              o;
        int                n_items, sent = 0, got = 0, cyc = 0;
        n_items = (mode_sel == 0) ? 6 : 12;
        sop = MODE_W'($urandom_range(0, 3));
        pp = rand_pp();
        while ((sent < n_items || sb.size() > 0) && cyc < 300) begin
            if (mode_sel == 0) begin
                op   = (sent < 4) ? 2'd0 : 2'd2;
                ordy = 1'($urandom_range(0, 1));
            end else begin
                op   = sop;
                ordy = cyc[0];
            end
            xr = exp_ready(sb.size(), sent < n_items, op, ordy);
            step(sent < n_items, pp, op, ordy, ir, o, ov);
            vectors++;
            if (ir !== xr) begin
                errors++;
                $display("FAIL stream%0d_ready cyc=%0d: in_ready=%0b, required %0b (in flight %0d)",
                         mode_sel, cyc, ir, xr, sb.size());
            end
            if (ov && ordy) begin
                vectors++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL stream%0d_spurious cyc=%0d: out_valid=1, required 0", mode_sel, cyc);
                end else begin
                    if (o !== sb[0]) begin
                        errors++;
                        $display("FAIL stream%0d_data item=%0d: mask=%h op=%0d, required mask=%h op=%0d",
                                 mode_sel, got, o.mask, o.op, sb[0].mask, sb[0].op);
                    end
                    void'(sb.pop_front());
                    got++;
                end
            end
            if (sent < n_items && ir) begin
                sb.push_back(model(pp, op));
                last_op = op;
                sent++;
                pp = rand_pp();
            end
            vectors++;
            if (sb.size() > 2) begin
                errors++;
                $display("FAIL stream%0d_occupancy cyc=%0d: in flight %0d, required <= 2", mode_sel, cyc, sb.size());
            end
            cyc++;
        end
        vectors++;
        if (got != n_items) begin
            errors++;
            $display("FAIL stream%0d_count: results=%0d, required %0d", mode_sel, got, n_items);
        end
    endtask

    task automatic test_reset_midflight();
        logic [PPW-1:0] pp;
        logic           ir, ov;
        res_t           o;
        step(1'b1, rand_pp(), 2'd1, 1'b0, ir, o, ov);
        step(1'b1, rand_pp(), 2'd1, 1'b0, ir, o, ov);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, out_pp, out_mask, out_op, out_illegal} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: valid=%0b mask=%h op=%0d, required all zero",
                     out_valid, out_mask, out_op);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        pp = rand_pp();
        step(1'b1, pp, 2'd2, 1'b1, ir, o, ov);
        vectors++;
        if (ir !== 1'b1 || ov !== 1'b0) begin
            errors++;
            $display("FAIL midreset_accept: in_ready=%0b out_valid=%0b, required 1 0", ir, ov);
        end
        step(1'b0, '0, '0, 1'b1, ir, o, ov);
        vectors++;
        if (ov !== 1'b0) begin
            errors++;
            $display("FAIL midreset_stale: out_valid=%0b, required 0", ov);
        end
        step(1'b0, '0, '0, 1'b1, ir, o, ov);
        vectors++;
        if (ov !== 1'b1 || o !== model(pp, 2'd2)) begin
            errors++;
            $display("FAIL midreset_result: valid=%0b mask=%h, required 1 ffff", ov, o.mask);
        end
        last_op = 2'd2;
    endtask

    initial begin
        test_reset();
        test_mode_sweep();
        test_throughput();
        test_backpressure();
        test_stream(0);
        test_stream(1);
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
